// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREP   = 2'd1,
    CHANGE = 2'd2,
    DENY   = 2'd3
  } state_t;

  // Value of one credit unit in won.
  localparam int UNIT_WON = 500;

  // Extract price field idx (each w bits wide) from a packed price vector.
  // Supports price vectors up to 256 bits and fields up to 16 bits.
  function automatic logic [15:0] price_field(input logic [255:0] prices,
                                              input int idx,
                                              input int w);
    logic [255:0] sh;
    sh = prices >> (idx * w);
    return sh[15:0] & ((16'd1 << w) - 16'd1);
  endfunction

endpackage

// File: rtl/vending_tick_gen.sv
// Free-running divider that pulses tick once every TICK_DIV clocks.
// Latency: tick is high during the last count of each period (combinational from the counter).
// Backpressure: none; never restarted by the FSM.
// Ports: clk (clock), SW3 (async active-low reset), tick (one-clock pulse).
module vending_tick_gen #(
  parameter int TICK_DIV = 6000000
) (
  input  logic clk,
  input  logic SW3,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/vending_ctrl_n.sv
// N-item vending controller: credit, per-item stock, timed PREP, DENY blink, change handshake.
// Latency: decisions take effect on the clock edge after the input pulse; PREP/DENY last a number of ticks.
// Backpressure: change units are offered on change_valid and held until change_ack; coins outside IDLE/DENY are rejected.
// Ports: clk, SW3 (async active-low reset), coin1/coin2/sel/refund/restock pulses, change_ack;
//        credit, sold_out, coin_reject, vend_valid, vend_item, change_valid, busy, err_blink.
module vending_ctrl_n
  import vending_pkg::*;
#(
  parameter int N_ITEMS    = 3,
  parameter int CREDIT_W   = 4,
  parameter int PRICE_W    = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {4'd6, 4'd5, 4'd3},
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 3,
  parameter int TICK_DIV   = 6000000,
  parameter int PREP_TICKS = 6,
  parameter int DENY_TICKS = 4,
  localparam int VI_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                SW3,
  input  logic                coin1,
  input  logic                coin2,
  input  logic [N_ITEMS-1:0]  sel,
  input  logic                refund,
  input  logic                restock,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                coin_reject,
  output logic                vend_valid,
  output logic [VI_W-1:0]     vend_item,
  output logic                change_valid,
  output logic                busy,
  output logic                err_blink
);

  // Arithmetic width wide enough for credit + 3 and for credit/price compares.
  localparam int AW   = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 2;
  localparam int MAXT = (PREP_TICKS > DENY_TICKS) ? PREP_TICKS : DENY_TICKS;
  localparam int TW   = (MAXT > 0) ? $clog2(MAXT + 1) : 1;
  localparam logic [AW-1:0] CREDIT_MAX = AW'((2 ** CREDIT_W) - 1);

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [VI_W-1:0]     vend_item_nxt;
  logic                reject_nxt, vend_nxt, blink_nxt;
  logic [STOCK_W-1:0]  stock     [N_ITEMS];
  logic [STOCK_W-1:0]  stock_nxt [N_ITEMS];

  logic                tick;
  logic                coin_any, coin_ok;
  logic [AW-1:0]       credit_ext, coin_val, coin_sum, price_ext;
  logic [VI_W-1:0]     sel_idx;
  logic [PRICE_W-1:0]  sel_price;

  vending_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .SW3  (SW3),
    .tick (tick)
  );

  // Lowest set select bit wins: scan downward so the lowest index is written last.
  always_comb begin
    sel_idx = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (sel[i]) sel_idx = VI_W'(i);
    end
  end

  assign sel_price  = PRICE_W'(price_field(256'(PRICES), int'(sel_idx), PRICE_W));
  assign price_ext  = AW'(sel_price);
  assign credit_ext = AW'(credit);
  // {coin2,coin1} read as a 2-bit number is exactly the coin value (0..3).
  assign coin_val   = AW'({coin2, coin1});
  assign coin_sum   = credit_ext + coin_val;
  assign coin_any   = coin1 | coin2;
  assign coin_ok    = (coin_sum <= CREDIT_MAX);

  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) begin
      state       <= IDLE;
      credit      <= '0;
      timer       <= '0;
      vend_item   <= '0;
      coin_reject <= 1'b0;
      vend_valid  <= 1'b0;
      err_blink   <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      timer       <= timer_nxt;
      vend_item   <= vend_item_nxt;
      coin_reject <= reject_nxt;
      vend_valid  <= vend_nxt;
      err_blink   <= blink_nxt;
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= stock_nxt[i];
    end
  end

  always_comb begin
    state_nxt     = state;
    credit_nxt    = credit;
    timer_nxt     = timer;
    vend_item_nxt = vend_item;
    reject_nxt    = 1'b0;
    vend_nxt      = 1'b0;
    blink_nxt     = err_blink;
    for (int i = 0; i < N_ITEMS; i++) stock_nxt[i] = stock[i];

    case (state)
      IDLE: begin
        if (refund) begin
          // A coin arriving alongside a higher-priority request is not taken.
          reject_nxt = coin_any;
          if (credit != '0) state_nxt = CHANGE;
        end else if (|sel) begin
          reject_nxt    = coin_any;
          vend_item_nxt = sel_idx;
          if ((stock[sel_idx] == '0) || (credit_ext < price_ext)) begin
            state_nxt = DENY;
            timer_nxt = TW'(DENY_TICKS);
            blink_nxt = 1'b0;
          end else begin
            state_nxt          = PREP;
            timer_nxt          = TW'(PREP_TICKS);
            credit_nxt         = CREDIT_W'(credit_ext - price_ext);
            stock_nxt[sel_idx] = stock[sel_idx] - STOCK_W'(1);
          end
        end else if (restock) begin
          reject_nxt = coin_any;
          for (int i = 0; i < N_ITEMS; i++) stock_nxt[i] = STOCK_W'(STOCK_INIT);
        end else if (coin_any) begin
          if (coin_ok) credit_nxt = CREDIT_W'(coin_sum);
          else         reject_nxt = 1'b1;
        end
      end

      PREP: begin
        reject_nxt = coin_any;
        if (tick) begin
          if (timer <= TW'(1)) begin
            timer_nxt = '0;
            vend_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
      end

      CHANGE: begin
        reject_nxt = coin_any;
        // change_valid is high for the whole CHANGE state, so ack alone is a handshake.
        if (change_ack) begin
          credit_nxt = credit - CREDIT_W'(1);
          if (credit <= CREDIT_W'(1)) state_nxt = IDLE;
        end
      end

      DENY: begin
        if (coin_any) begin
          if (coin_ok) credit_nxt = CREDIT_W'(coin_sum);
          else         reject_nxt = 1'b1;
        end
        if (tick) begin
          if (timer <= TW'(1)) begin
            timer_nxt = '0;
            blink_nxt = 1'b0;
            state_nxt = IDLE;
          end else begin
            timer_nxt = timer - TW'(1);
            blink_nxt = ~err_blink;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_ITEMS; i++) sold_out[i] = (stock[i] == '0);
  end

  assign busy         = (state != IDLE);
  assign change_valid = (state == CHANGE);

endmodule
